conf_reg_sink: RTL

- Responder end of the CONF configuration channel.
- Accepts (c_addr, c_data) write beats on a valid/ready handshake and buffers them in a small FIFO.
- Commits buffered beats into a local register bank, one per cycle, under apply_en.
- Sits at the consumer side of every CONF source; downstream logic reads the bank through a registered read port and is notified of each commit.

---
 rtl/conf_reg_sink.sv | 125 ++++++++++++
 1 files changed

// File: rtl/conf_reg_sink.sv
// CONF channel responder: buffers (c_addr, c_data) beats in a FIFO and commits them to a register bank.
// Optional error counter (err_cnt/err_clr) is built when CONF_ERR_CNT_EN is defined.
module conf_reg_sink #(
    parameter int unsigned c_addr_WIDTH = 8,
    parameter int unsigned c_data_WIDTH = 32,
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          c_valid,
    input  logic [c_addr_WIDTH-1:0]       c_addr,
    input  logic [c_data_WIDTH-1:0]       c_data,
    output logic                          c_ready,
    input  logic                          apply_en,
    input  logic [c_addr_WIDTH-1:0]       rd_addr,
    output logic [c_data_WIDTH-1:0]       rd_data,
    output logic                          cfg_update,
    output logic [c_addr_WIDTH-1:0]       upd_addr,
    output logic                          err_addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef CONF_ERR_CNT_EN
    ,
    input  logic                          err_clr,
    output logic [15:0]                   err_cnt
`endif
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned AEXT_W = c_addr_WIDTH + 1;

    // Address bound extended by one bit so NUM_REGS == 2**c_addr_WIDTH still fits.
    localparam logic [AEXT_W-1:0] NUM_REGS_A = AEXT_W'(NUM_REGS);
    localparam logic [LVL_W-1:0]  DEPTH_L    = LVL_W'(FIFO_DEPTH);

    logic [c_addr_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [c_data_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [c_data_WIDTH-1:0] bank      [NUM_REGS];

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        count;
    logic [LVL_W-1:0]        count_nxt;

    logic                    push_c;
    logic                    pop_c;
    logic                    head_ok_c;
    logic                    rd_ok_c;
    logic [c_addr_WIDTH-1:0] head_addr_c;
    logic [c_data_WIDTH-1:0] head_data_c;

    // Handshake, pop decision and next occupancy.
    always_comb begin
        push_c      = c_valid && c_ready;
        pop_c       = (count != '0) && apply_en;
        head_addr_c = fifo_addr[rd_ptr];
        head_data_c = fifo_data[rd_ptr];
        head_ok_c   = {1'b0, head_addr_c} < NUM_REGS_A;
        rd_ok_c     = {1'b0, rd_addr} < NUM_REGS_A;
        count_nxt   = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt = count + LVL_W'(1);
            2'b01:   count_nxt = count - LVL_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO control; c_ready looks only at next occupancy, so a pop never frees a same-edge push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            c_ready    <= 1'b0;
            fifo_level <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nxt;
            c_ready    <= count_nxt < DEPTH_L;
            fifo_level <= count_nxt;
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_addr[wr_ptr] <= c_addr;
            fifo_data[wr_ptr] <= c_data;
        end
    end

    // Register bank, commit pulses and readback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) bank[i] <= '0;
            rd_data    <= '0;
            cfg_update <= 1'b0;
            upd_addr   <= '0;
            err_addr   <= 1'b0;
        end else begin
            if (pop_c && head_ok_c) begin
                bank[head_addr_c[IDX_W-1:0]] <= head_data_c;
                upd_addr <= head_addr_c;
            end
            cfg_update <= pop_c && head_ok_c;
            err_addr   <= pop_c && !head_ok_c;
            rd_data    <= rd_ok_c ? bank[rd_addr[IDX_W-1:0]] : '0;
        end
    end

`ifdef CONF_ERR_CNT_EN
    // Saturating count of discarded beats; clear wins over a coincident error.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (pop_c && !head_ok_c && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
